serial_subtractor_nbit: RTL and testbench



---
 rtl/serial_subtractor_nbit.sv | 125 ++++++++++++
 tb/tb_serial_subtractor_nbit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial a - b - borrow_in (LSB first, via a + ~b + ~borrow_in); optional SUB_INPUT_CHECK_EN adds sim-only X/Z checks on accepted inputs.
// Latency: start sampled at edge E0 -> done pulse after edge E_BIT_WIDTH; back-to-back one result per BIT_WIDTH+1 cycles.
// Backpressure: none; start is only accepted in IDLE/DONE and is ignored while busy.
module serial_subtractor_nbit #(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic [BIT_WIDTH-1:0] difference,
    output logic                 borrow_out,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(BIT_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic                 a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic                 bo_q, bo_d, ov_q, ov_d;
    logic                 sum_bit, carry_nxt, accept;

    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        bo_d    = bo_q;
        ov_d    = ov_q;
        case (state_q)
            CALC: begin
                a_d     = {1'b0, a_q[BIT_WIDTH-1:1]};
                b_d     = {1'b0, b_q[BIT_WIDTH-1:1]};
                res_d   = {sum_bit, res_q[BIT_WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Result regs update only here so partial sums never reach the outputs.
                    diff_d  = {sum_bit, res_q[BIT_WIDTH-1:1]};
                    bo_d    = ~carry_nxt;
                    ov_d    = (a_msb_q != b_msb_q) && (sum_bit != a_msb_q);
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    a_d     = a;
                    b_d     = ~b;
                    carry_d = ~borrow_in;
                    cnt_d   = '0;
                    a_msb_d = a[BIT_WIDTH-1];
                    b_msb_d = b[BIT_WIDTH-1];
                    state_d = CALC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
        end
    end

    assign difference = diff_q;
    assign borrow_out = bo_q;
    assign overflow   = ov_q;
    assign busy       = (state_q == CALC);
    assign done       = (state_q == DONE);

`ifdef SUB_INPUT_CHECK_EN
    always @(posedge clk) begin
        if (n_rst && accept) begin
            for (int i = 0; i < BIT_WIDTH; i++) begin
                assert (!$isunknown(a[i])) else $error("input a bit %0d is not 0/1", i);
                assert (!$isunknown(b[i])) else $error("input b bit %0d is not 0/1", i);
            end
            assert (!$isunknown(borrow_in)) else $error("input borrow_in bit 0 is not 0/1");
        end
    end
`else
    // Input checking compiled out.
`endif
endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Scoreboard bench for serial_subtractor_nbit: stimulus pushes expected results, a negedge monitor pops on done.
module tb_serial_subtractor_nbit;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic [W-1:0] difference;
    logic         borrow_out, overflow, busy, done;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    serial_subtractor_nbit #(.BIT_WIDTH(W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
        .difference(difference), .borrow_out(borrow_out), .overflow(overflow),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (n_rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("difference", int'(difference), int'(e.diff));
                check("borrow_out", int'(borrow_out), int'(e.bo));
                check("overflow",   int'(overflow),   int'(e.ov));
            end
        end
    end

    // Start an op, then count negedges until done: done must appear W+1 negedges
    // after start is driven (sampled at E0, done after E_W); busy seen on W of them.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input logic [W-1:0] ediff, input logic ebo, input logic eov);
        int lat, busy_cnt;
        logic stable;
        logic [W-1:0] prev;
        exp_t e;
        @(negedge clk);
        prev = difference;
        a = ta; b = tb_; borrow_in = tbin; start = 1'b1;
        e.diff = ediff; e.bo = ebo; e.ov = eov;
        sb.push_back(e);
        lat = 0; busy_cnt = 0; stable = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            a = ~ta; b = ~tb_; borrow_in = ~tbin;
            lat++;
            if (busy) begin
                busy_cnt++;
                if (difference != prev) stable = 1'b0;
            end
        end while (!done && lat < 50);
        check("latency", lat, W + 1);
        check("busy_cycles", busy_cnt, W);
        check("outputs_stable_in_calc", int'(stable), 1);
    endtask

    initial begin
        int lat;
        exp_t e;
        #12;
        check("rst_difference", int'(difference), 0);
        check("rst_borrow_out", int'(borrow_out), 0);
        check("rst_overflow",   int'(overflow), 0);
        check("rst_busy",       int'(busy), 0);
        check("rst_done",       int'(done), 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Directed vectors (W=4), expectations computed by hand.
        run_op(4'd7,  4'd3,  1'b0, 4'd4,  1'b0, 1'b0);
        run_op(4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0);
        run_op(4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0);
        run_op(4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1);
        run_op(4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1);
        run_op(4'd5,  4'd5,  1'b1, 4'd15, 1'b1, 1'b0);
        run_op(4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0);
        run_op(4'd12, 4'd6,  1'b1, 4'd5,  1'b0, 1'b1);
        run_op(4'd0,  4'd8,  1'b0, 4'd8,  1'b1, 1'b1);

        // Start re-pulsed during CALC is ignored; start held into DONE chains the next op.
        @(negedge clk);
        a = 4'd6; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
        e.diff = 4'd4; e.bo = 1'b0; e.ov = 1'b0; sb.push_back(e);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; a = 4'd1; b = 4'd1;
        @(negedge clk); a = 4'd3; b = 4'd2;
        @(negedge clk); a = 4'd9; b = 4'd4;
        @(negedge clk);
        check("first_done_on_time", int'(done), 1);
        e.diff = 4'd5; e.bo = 1'b0; e.ov = 1'b1; sb.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 50);
        check("back_to_back_period", lat, W + 1);

        // Asynchronous reset mid-CALC aborts with no done pulse.
        @(negedge clk);
        a = 4'd5; b = 4'd1; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("abort_difference", int'(difference), 0);
        check("abort_borrow_out", int'(borrow_out), 0);
        check("abort_overflow",   int'(overflow), 0);
        check("abort_busy",       int'(busy), 0);
        check("abort_done",       int'(done), 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (6) @(negedge clk);
        check("no_done_after_abort", int'(done), 0);
        run_op(4'd2, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 50000");
        $fatal(1, "timeout");
    end
endmodule
